// File: rtl/quotient_bcd_conv_pkg.sv
// Shared constants for the quotient-to-BCD converter: one-hot FSM encoding and
// the double-dabble adjust threshold.
package quotient_bcd_conv_pkg;

  // One-hot state encoding, same style as the existing controller FSMs.
  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_ADJUST = 4'b0010;
  localparam logic [3:0] ST_SHIFT  = 4'b0100;
  localparam logic [3:0] ST_DONE   = 4'b1000;

  typedef enum logic [3:0] {
    StIdle   = ST_IDLE,
    StAdjust = ST_ADJUST,
    StShift  = ST_SHIFT,
    StDone   = ST_DONE
  } state_e;

  // A digit at or above this value gets +3 before the next shift.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble adjust cell for a single BCD digit.
module bcd_digit_adj
  import quotient_bcd_conv_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  // Inputs never exceed 9, so the result is at most 12 and fits in 4 bits.
  assign digit_o = (digit_i >= BCD_ADJ_THRESH) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/quotient_bcd_conv.sv
// Sequential binary-to-BCD converter for the divider quotient. One adjust
// cycle and one shift cycle per input bit; the result is copied to the output
// registers in the DONE cycle and held until the next conversion completes.
module quotient_bcd_conv
  import quotient_bcd_conv_pkg::*;
#(
  parameter int unsigned WIDTH  = 7,
  parameter int unsigned DIGITS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       bcd_hundreds_o,
  output logic [3:0]       bcd_tens_o,
  output logic [3:0]       bcd_ones_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic [BcdW-1:0]   bcd_adj;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  // Next-state and datapath update for the FSM.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = bin_i;
          bcd_d   = '0;
          cnt_d   = CntW'(WIDTH);
          state_d = StAdjust;
        end
      end
      StAdjust: begin
        bcd_d   = bcd_adj;
        state_d = StShift;
      end
      StShift: begin
        {bcd_d, bin_d} = {bcd_q, bin_q} << 1;
        cnt_d          = cnt_q - CntW'(1);
        // Compare the pre-decrement count: the last bit has just been shifted.
        state_d        = (cnt_q == CntW'(1)) ? StDone : StAdjust;
      end
      StDone: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, scratch and output registers; reset abandons any conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  // Moore status outputs decoded from the one-hot state.
  always_comb begin
    busy_o = (state_q == StAdjust) || (state_q == StShift);
    done_o = (state_q == StDone);
  end

  assign bcd_hundreds_o = hund_q;
  assign bcd_tens_o     = tens_q;
  assign bcd_ones_o     = ones_q;

endmodule

// File: doc/quotient_bcd_conv.md
# quotient_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the divider and consumes its 7-bit quotient. It converts the quotient to three packed BCD digits for the display path using a shift-and-add-3 (double-dabble) datapath, one adjust and one shift step per input bit. Results are held in output registers until the next conversion completes.

## Interface
- `WIDTH`, default 7: binary input width.
- `DIGITS`, default 3: BCD digit count. Must satisfy 10^DIGITS > 2^WIDTH − 1. Ports below are written for the defaults.

- `clk`: in, 1; single clock, rising edge.
- `rst_n`: in, 1; asynchronous, active-low reset.
- `start_i`: in, 1; request a conversion. Sampled only in IDLE.
- `bin_i`: in, WIDTH; unsigned value to convert. Sampled on the same edge as `start_i`.
- `busy_o`: out, 1; high while a conversion is in progress (ADJUST/SHIFT states).
- `done_o`: out, 1; one-cycle pulse; BCD outputs are newly valid.
- `bcd_hundreds_o`: out, 4; hundreds digit.
- `bcd_tens_o`: out, 4; tens digit.
- `bcd_ones_o`: out, 4; ones digit.

## Operation
- Datapath:
  - `bin_sr`: WIDTH-bit shift register.
  - `bcd_sr`: 4×DIGITS-bit scratch register.
  - `bit_cnt`: counter of width clog2(WIDTH+1).
  - Output registers: `bcd_*_o`.
- FSM is one-hot with four states: IDLE, ADJUST, SHIFT, DONE.
  - **IDLE**: if `start_i`, load `bin_sr` ← `bin_i`, clear `bcd_sr`, set `bit_cnt` ← WIDTH, go to ADJUST. Otherwise stay.
  - **ADJUST**: for each digit of `bcd_sr`, if digit ≥ 5, add 3 (4-bit add, no carry out). Go to SHIFT.
  - **SHIFT**:
    - `{bcd_sr, bin_sr}` ← `{bcd_sr, bin_sr} << 1`.
    - `bit_cnt` ← `bit_cnt` − 1.
    - If the pre-decrement `bit_cnt` == 1, go to DONE; else go to ADJUST.
  - **DONE**: copy `bcd_sr` to the output registers. Go to IDLE.
- `done_o` is high when state == DONE; it is a Moore output.
- `busy_o` is high when state ∈ {ADJUST, SHIFT}.
- `start_i` is ignored in ADJUST, SHIFT and DONE. Requests are not queued.
- Outputs hold their last value through every state except the DONE copy.
- Arithmetic: every digit stays in 0–9 after each SHIFT. The adjust never produces a digit above 12, so the 4-bit add cannot overflow.

## Timing
- Call the rising edge that samples `start_i` = 1 in IDLE edge 0. The FSM is then in ADJUST during cycle 1.
- ADJUST/SHIFT alternate for 2×WIDTH cycles, i.e. cycles 1–14 for the defaults.
- The FSM is in DONE during cycle 15:
  - `done_o` = 1 for exactly that cycle.
  - `bcd_*_o` take their new value at the end of cycle 15 (edge 15→16), registered. Consumers must sample them after the `done_o` cycle.
- Earliest next accepted start is at the edge ending cycle 16 (state IDLE). Throughput is one conversion per 2×WIDTH+2 cycles.
- Reset, asynchronous on `rst_n` low, at any time including mid-conversion:
  - State → IDLE.
  - `bin_sr`, `bcd_sr`, `bit_cnt` → 0.
  - `busy_o` = 0, `done_o` = 0.
  - All `bcd_*_o` = 0.
  - The conversion in progress is abandoned. No `done_o` is produced for it.
- `start_i` high on the same edge that `rst_n` deasserts: not accepted. The first sampling edge is the one after reset release.

## Structure
- Shared package: one-hot state constants `ST_IDLE`=4'b0001, `ST_ADJUST`=4'b0010, `ST_SHIFT`=4'b0100, `ST_DONE`=4'b1000. This matches the encoding style of the existing controller FSMs.
- Shared package: constant `BCD_ADJ_THRESH`=4'd5.
- Sub-module `bcd_digit_adj`: 4-bit combinational cell, digit_i → digit_o (= digit_i ≥ 5 ? digit_i + 3 : digit_i). Instantiate it DIGITS times with a generate loop.
- Everything else lives in the top module: FSM, counter, shift registers, output registers.

## Test plan
- Reset, then `bin_i`=7'd3 with a one-cycle `start_i` → `busy_o` high for cycles 1–14; `done_o` high in cycle 15 only; outputs 0/0/3.
- `bin_i`=7'd127 → outputs 1/2/7; `bin_i`=7'd0 → 0/0/0; `bin_i`=7'd100 → 1/0/0, each with `done_o` in cycle 15. Compare exhaustively over all 128 inputs against a reference model.
- Convert 7'd45, then pulse `start_i` with `bin_i`=7'd99 during cycle 5 and again during the DONE cycle → both requests ignored; outputs 0/4/5; no second `done_o`.
- Convert 7'd45, then 7'd82 started at the first IDLE cycle → outputs hold 0/4/5 until the second DONE copy, then read 0/8/2.
- Start 7'd64, assert `rst_n` low during cycle 7 → immediately `busy_o`=0 and outputs 0/0/0; after release, no `done_o` appears; a fresh start of 7'd64 gives 0/6/4.
